// File: rtl/writeback_unit.sv
// writeback_unit: queues execute results and drains them one per cycle into
// the register file write port. It also reports decode-stage read hazards
// against every write that has not yet landed in the register file, and
// forwards the newest pending value for each queried register.
module writeback_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       res_valid,
  input  logic [ADDR_W-1:0]          res_dest,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       res_ready,
  input  logic                       wb_stall,
  output logic                       writeEnable,
  output logic [ADDR_W-1:0]          write,
  output logic [DATA_W-1:0]          data,
  input  logic [ADDR_W-1:0]          read1,
  input  logic [ADDR_W-1:0]          read2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic [DATA_W-1:0]          fwd1,
  output logic [DATA_W-1:0]          fwd2,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Queue storage; an entry is meaningful only while it lies between head and tail.
  logic [ADDR_W-1:0] mem_dest_q [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;

  logic              push_s;
  logic              pop_s;
  logic              full_s;

  // Accept/drain decisions; full comes from registered occupancy only, so
  // res_ready has no path from res_valid or wb_stall.
  always_comb begin
    full_s = (count_q == FULL_CNT);
    push_s = res_valid && !full_s;
    pop_s  = (count_q != {CNT_W{1'b0}}) && !wb_stall;
  end

  // Next-state for pointers, occupancy and the write-port output register.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (pop_s) begin
      head_d = head_q + PTR_W'(1);
      we_d   = 1'b1;
      wa_d   = mem_dest_q[head_q];
      wd_d   = mem_data_q[head_q];
    end else begin
      we_d   = 1'b0;
    end
    if (push_s) begin
      tail_d = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset taking priority over push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      we_q    <= 1'b0;
      wa_q    <= {ADDR_W{1'b0}};
      wd_q    <= {DATA_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  // Queue storage write; no reset needed because occupancy gates validity.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_dest_q[tail_q] <= res_dest;
      mem_data_q[tail_q] <= res_data;
    end
  end

  // Hazard/forward lookup: scan oldest to youngest so the last match wins,
  // starting with the output register, then queue entries in age order.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    fwd1    = {DATA_W{1'b0}};
    fwd2    = {DATA_W{1'b0}};
    if (we_q && (wa_q == read1)) begin
      hazard1 = 1'b1;
      fwd1    = wd_q;
    end else begin
      hazard1 = 1'b0;
    end
    if (we_q && (wa_q == read2)) begin
      hazard2 = 1'b1;
      fwd2    = wd_q;
    end else begin
      hazard2 = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        if (mem_dest_q[head_q + PTR_W'(k)] == read1) begin
          hazard1 = 1'b1;
          fwd1    = mem_data_q[head_q + PTR_W'(k)];
        end else begin
          fwd1    = fwd1;
        end
        if (mem_dest_q[head_q + PTR_W'(k)] == read2) begin
          hazard2 = 1'b1;
          fwd2    = mem_data_q[head_q + PTR_W'(k)];
        end else begin
          fwd2    = fwd2;
        end
      end else begin
        fwd1 = fwd1;
      end
    end
  end

  assign res_ready   = !full_s;
  assign writeEnable = we_q;
  assign write       = wa_q;
  assign data        = wd_q;
  assign pending     = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed plus randomized bench for writeback_unit against a queue-based
// reference model of the pending-write behaviour.
module tb_writeback_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              res_valid = 1'b0;
  logic [ADDR_W-1:0] res_dest = '0;
  logic [DATA_W-1:0] res_data = '0;
  logic              res_ready;
  logic              wb_stall = 1'b0;
  logic              writeEnable;
  logic [ADDR_W-1:0] write;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] read1 = '0;
  logic [ADDR_W-1:0] read2 = '0;
  logic              hazard1, hazard2;
  logic [DATA_W-1:0] fwd1, fwd2;
  logic [$clog2(DEPTH):0] pending;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] val;
  } ent_t;

  // Reference model state: list of pending writes plus the last issued write.
  ent_t              mq[$];
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_wa = '0;
  logic [DATA_W-1:0] m_wd = '0;

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .res_valid(res_valid), .res_dest(res_dest), .res_data(res_data),
    .res_ready(res_ready), .wb_stall(wb_stall),
    .writeEnable(writeEnable), .write(write), .data(data),
    .read1(read1), .read2(read2),
    .hazard1(hazard1), .hazard2(hazard2), .fwd1(fwd1), .fwd2(fwd2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one clock edge: reset wins; otherwise drain the oldest entry if
  // allowed, and accept the offer only if the queue was not full beforehand.
  task automatic model_edge(input logic rs, input logic v, input logic [ADDR_W-1:0] d,
                            input logic [DATA_W-1:0] x, input logic st);
    bit was_full;
    ent_t e;
    if (rs) begin
      mq.delete();
      m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      was_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && !st) begin
        e = mq.pop_front();
        m_we = 1'b1; m_wa = e.dest; m_wd = e.val;
      end else begin
        m_we = 1'b0;
      end
      if (v && !was_full) begin
        e.dest = d; e.val = x;
        mq.push_back(e);
      end
    end
  endtask

  // Newest pending value for a register: youngest queue entry first, then
  // the write currently on the register-file port.
  task automatic model_lookup(input logic [ADDR_W-1:0] r, output logic h, output logic [DATA_W-1:0] f);
    h = 1'b0; f = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!h && mq[i].dest == r) begin h = 1'b1; f = mq[i].val; end
    end
    if (!h && m_we && m_wa == r) begin h = 1'b1; f = m_wd; end
  endtask

  task automatic check_all();
    logic h; logic [DATA_W-1:0] f;
    chk("writeEnable", 32'(writeEnable), 32'(m_we));
    chk("write", 32'(write), 32'(m_wa));
    chk("data", 32'(data), 32'(m_wd));
    chk("pending", 32'(pending), 32'(mq.size()));
    chk("res_ready", 32'(res_ready), 32'(mq.size() != DEPTH));
    model_lookup(read1, h, f);
    chk("hazard1", 32'(hazard1), 32'(h));
    chk("fwd1", 32'(fwd1), 32'(f));
    model_lookup(read2, h, f);
    chk("hazard2", 32'(hazard2), 32'(h));
    chk("fwd2", 32'(fwd2), 32'(f));
  endtask

  // One cycle: drive inputs, clock, update model, sample 1ns after the edge.
  task automatic step(input logic rs, input logic v, input logic [ADDR_W-1:0] d,
                      input logic [DATA_W-1:0] x, input logic st,
                      input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    reset = rs; res_valid = v; res_dest = d; res_data = x; wb_stall = st;
    read1 = r1; read2 = r2;
    @(posedge clk);
    model_edge(rs, v, d, x, st);
    #1;
    check_all();
  endtask

  initial begin
    #2;
    // Reset state
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd1);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd6, 4'd0);
    chk("rst_ready", 32'(res_ready), 32'd1);
    chk("rst_pending", 32'(pending), 32'd0);

    // Single write: push (6,143), issued on the following edge
    step(1'b0, 1'b1, 4'd6, 16'd143, 1'b0, 4'd6, 4'd0);
    chk("single_haz_queued", 32'(hazard1), 32'd1);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd6, 4'd0);
    chk("single_we", 32'(writeEnable), 32'd1);
    chk("single_addr", 32'(write), 32'd6);
    chk("single_data", 32'(data), 32'd143);
    chk("single_pending", 32'(pending), 32'd0);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd6, 4'd0);
    chk("single_we_off", 32'(writeEnable), 32'd0);

    // Fill under stall, fifth offer refused, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 4'(i), 16'(10 * i), 1'b1, 4'd2, 4'd4);
    chk("fill_pending", 32'(pending), 32'd4);
    chk("fill_ready", 32'(res_ready), 32'd0);
    step(1'b0, 1'b1, 4'd9, 16'd99, 1'b1, 4'd9, 4'd1);
    chk("fill_5th_refused", 32'(hazard1), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd9, 4'd1);
      chk("drain_addr", 32'(write), 32'(i));
      chk("drain_data", 32'(data), 32'(10 * i));
    end
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd9, 4'd1);
    chk("drain_done", 32'(writeEnable), 32'd0);

    // Hazard / forward: two writes to r3, newest wins
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd3, 16'd100, 1'b1, 4'd3, 4'd2);
    step(1'b0, 1'b1, 4'd3, 16'd200, 1'b1, 4'd3, 4'd2);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 4'd2);
    chk("fwd_haz1", 32'(hazard1), 32'd1);
    chk("fwd_val1", 32'(fwd1), 32'd200);
    chk("fwd_haz2", 32'(hazard2), 32'd0);
    chk("fwd_val2", 32'(fwd2), 32'd0);

    // Steady push/pop stream 5,6,7
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0);
    for (int i = 5; i <= 7; i++) begin
      step(1'b0, 1'b1, 4'(i), 16'(i * 3), 1'b0, 4'd5, 4'd7);
      chk("stream_pending", 32'(pending), 32'd1);
    end
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd5, 4'd7);
    chk("stream_last", 32'(write), 32'd7);

    // Stall mid-stream with two queued entries
    step(1'b0, 1'b1, 4'd8, 16'd800, 1'b1, 4'd8, 4'd9);
    step(1'b0, 1'b1, 4'd9, 16'd900, 1'b1, 4'd8, 4'd9);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd8, 4'd9);
    chk("stall_we", 32'(writeEnable), 32'd0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd8, 4'd9);

    // Reset mid-operation with an offer pending
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'(i + 10), 16'(i + 1000), 1'b1, 4'd10, 4'd11);
    step(1'b1, 1'b1, 4'd10, 16'd55, 1'b0, 4'd10, 4'd11);
    chk("midrst_pending", 32'(pending), 32'd0);
    chk("midrst_write", 32'(write), 32'd0);
    chk("midrst_haz1", 32'(hazard1), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0, 4'($urandom), 16'($urandom),
           ($urandom % 3) == 0, 4'($urandom), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning result/register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register address width (16 registers).
REQ-003 SHALL have parameter DEPTH, default 4, meaning pending-write queue entries (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port res_valid  input  1  execute result offered.
REQ-007 SHALL have port res_dest  input  ADDR_W  destination register of offered result.
REQ-008 SHALL have port res_data  input  DATA_W  offered result value.
REQ-009 SHALL have port res_ready  output  1  unit can accept a result this cycle.
REQ-010 SHALL have port wb_stall  input  1  register file write port unavailable; hold queue.
REQ-011 SHALL have port writeEnable  output  1  register file write strobe.
REQ-012 SHALL have port write  output  ADDR_W  register file write address.
REQ-013 SHALL have port data  output  DATA_W  register file write data.
REQ-014 SHALL have ports read1, read2  input  ADDR_W each  decode-stage read addresses under query.
REQ-015 SHALL have ports hazard1, hazard2  output  1 each  pending write exists for read1/read2.
REQ-016 SHALL have ports fwd1, fwd2  output  DATA_W each  newest pending value for read1/read2.
REQ-017 SHALL have port pending  output  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-018 SHALL hold results in a FIFO of DEPTH entries {dest, data}; head/tail pointers wrap modulo DEPTH; pending counts 0..DEPTH.
REQ-019 SHALL drive res_ready = (pending != DEPTH), from registered state only (no combinational path from res_valid or wb_stall).
REQ-020 SHALL push on a posedge where res_valid && res_ready; res_dest/res_data are ignored when no push occurs.
REQ-021 SHALL pop the head on a posedge where pending != 0 and wb_stall == 0, loading write/data with head entry and setting writeEnable = 1.
REQ-022 SHALL set writeEnable = 0 on any posedge with no pop; write/data then hold their last values.
REQ-023 SHALL issue each accepted result exactly once, in acceptance order; stall never re-issues or drops.
REQ-024 SHALL on simultaneous push and pop (pending not full) keep pending unchanged and advance both pointers.
REQ-025 SHALL never push when full, even if a pop occurs the same edge; the offered result must be re-offered.
REQ-026 SHALL have latency: result pushed at edge N into an empty queue, with wb_stall low, drives writeEnable high from edge N+1 to N+2.
REQ-027 SHALL assert hazardK when any valid queue entry, or the output register while writeEnable = 1, has dest == readK (K = 1, 2).
REQ-028 SHALL drive fwdK with the data of the youngest matching entry (queue tail side youngest, output register oldest); fwdK = 0 when hazardK = 0.
REQ-029 SHALL compute hazard/fwd combinationally from readK and registered state within the same cycle.
REQ-030 SHALL treat register 0 as an ordinary register (no special casing).

Reset
REQ-031 SHALL on posedge with reset = 1 clear pointers, pending = 0, writeEnable = 0, write = 0, data = 0; queue contents become invalid.
REQ-032 SHALL give reset priority over a simultaneous push or pop; results offered in that cycle are discarded.
REQ-033 SHALL after reset drive res_ready = 1, hazard1 = hazard2 = 0, fwd1 = fwd2 = 0.

Verification
REQ-034 Single write: reset, then push dest 6, data 143, stall 0 -> next edge writeEnable = 1, write = 6, data = 143 for one cycle; pending returns to 0.
REQ-035 Fill/backpressure: wb_stall = 1, push 4 results (regs 1..4, data 10..40) -> pending = 4, res_ready = 0, 5th offer not accepted; release stall -> writes 1,2,3,4 on four consecutive cycles, then writeEnable = 0.
REQ-036 Hazard/forward: stall 1, push (3,100) then (3,200), read1 = 3, read2 = 2 -> hazard1 = 1, fwd1 = 200, hazard2 = 0, fwd2 = 0.
REQ-037 Simultaneous push/pop: steady res_valid with stall 0, dests 5,6,7 -> pending stays at most 1, writes appear in order 5,6,7 one cycle after each push.
REQ-038 Stall mid-stream: queue holds 2 entries, wb_stall = 1 for 3 cycles -> writeEnable = 0 during stall, no duplicate or lost write afterwards.
REQ-039 Reset mid-operation: pending = 3 and res_valid = 1 at reset edge -> after edge pending = 0, writeEnable = 0, write = 0, data = 0, hazards 0.
